// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline boundary.
package pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ID_W   = 5;
  localparam int unsigned CTRL_W_DEF = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stage_state_e;

  // Fixed-width part of the ID/EX payload; the opaque control bundle travels separately.
  typedef struct packed {
    logic                valid;
    logic                rf_we;
    logic                mem_rd;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm;
    logic [REG_ID_W-1:0] ra1;
    logic [REG_ID_W-1:0] ra2;
    logic [REG_ID_W-1:0] wa;
  } id_ex_data_t;

  localparam id_ex_data_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic                i_ex_valid,
  input  logic                i_ex_mem_rd,
  input  logic [REG_ID_W-1:0] i_ex_wa,
  input  logic                i_id_valid,
  input  logic                i_id_use_ra1,
  input  logic                i_id_use_ra2,
  input  logic [REG_ID_W-1:0] i_id_ra1,
  input  logic [REG_ID_W-1:0] i_id_ra2,
  output logic                o_hazard_c
);

  logic w_ex_load;
  logic w_match1;
  logic w_match2;

  // A load to x0 never produces a value worth waiting for.
  assign w_ex_load  = i_ex_valid & i_ex_mem_rd & (i_ex_wa != '0);
  assign w_match1   = i_id_use_ra1 & (i_id_ra1 == i_ex_wa);
  assign w_match2   = i_id_use_ra2 & (i_id_ra2 == i_ex_wa);
  assign o_hazard_c = w_ex_load & i_id_valid & (w_match1 | w_match2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and branch flush.
// Define IDEX_BUBBLE_CNT_EN to add the o_bubble_cnt hazard-bubble counter port.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W          = CTRL_W_DEF,
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  input  logic [XLEN-1:0]     i_id_pc,
  input  logic [XLEN-1:0]     i_id_rd1,
  input  logic [XLEN-1:0]     i_id_rd2,
  input  logic [XLEN-1:0]     i_id_imm,
  input  logic [REG_ID_W-1:0] i_id_ra1,
  input  logic [REG_ID_W-1:0] i_id_ra2,
  input  logic [REG_ID_W-1:0] i_id_wa,
  input  logic                i_id_use_ra1,
  input  logic                i_id_use_ra2,
  input  logic                i_id_rf_we,
  input  logic                i_id_mem_rd,
  input  logic [CTRL_W-1:0]   i_id_ctrl,
  input  logic                i_flush,
  output logic                o_ex_valid,
  output logic                o_ex_rf_we,
  output logic                o_ex_mem_rd,
  output logic [XLEN-1:0]     o_ex_pc,
  output logic [XLEN-1:0]     o_ex_rd1,
  output logic [XLEN-1:0]     o_ex_rd2,
  output logic [XLEN-1:0]     o_ex_imm,
  output logic [REG_ID_W-1:0] o_ex_ra1,
  output logic [REG_ID_W-1:0] o_ex_ra2,
  output logic [REG_ID_W-1:0] o_ex_wa,
  output logic [CTRL_W-1:0]   o_ex_ctrl,
  output logic                o_stall_if_id_c
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]         o_bubble_cnt
`endif
);

  stage_state_e        r_state;
  stage_state_e        w_state_nxt;
  logic [1:0]          r_rem;
  logic [1:0]          w_rem_nxt;
  logic                w_hazard;
  logic                w_stall;
  logic                w_bubble;
  id_ex_data_t         r_ex;
  id_ex_data_t         w_id_data;
  logic [CTRL_W-1:0]   r_ex_ctrl;

  load_use_detect u_detect (
    .i_ex_valid   (r_ex.valid),
    .i_ex_mem_rd  (r_ex.mem_rd),
    .i_ex_wa      (r_ex.wa),
    .i_id_valid   (i_id_valid),
    .i_id_use_ra1 (i_id_use_ra1),
    .i_id_use_ra2 (i_id_use_ra2),
    .i_id_ra1     (i_id_ra1),
    .i_id_ra2     (i_id_ra2),
    .o_hazard_c   (w_hazard)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_rem   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next state: the hazard edge itself is the first bubble, STALL covers the rest.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (i_flush) begin
      w_state_nxt = ST_RUN;
      w_rem_nxt   = 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard && (LOAD_USE_STALLS > 1)) begin
            w_state_nxt = ST_STALL;
            w_rem_nxt   = 2'(LOAD_USE_STALLS - 1);
          end
        end
        ST_STALL: begin
          w_rem_nxt = r_rem - 2'd1;
          if (r_rem == 2'd1) w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Outputs: flush bubbles the stage but never holds the front end.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    if (i_flush) begin
      w_bubble = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_stall  = w_hazard;
          w_bubble = w_hazard;
        end
        ST_STALL: begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
        default: begin
          w_stall  = 1'b0;
          w_bubble = 1'b0;
        end
      endcase
    end
  end

  assign w_id_data = '{
    valid:  i_id_valid,
    rf_we:  i_id_rf_we,
    mem_rd: i_id_mem_rd,
    pc:     i_id_pc,
    rd1:    i_id_rd1,
    rd2:    i_id_rd2,
    imm:    i_id_imm,
    ra1:    i_id_ra1,
    ra2:    i_id_ra2,
    wa:     i_id_wa
  };

  // EX register bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex      <= ID_EX_BUBBLE;
      r_ex_ctrl <= '0;
    end else if (w_bubble) begin
      r_ex      <= ID_EX_BUBBLE;
      r_ex_ctrl <= '0;
    end else begin
      r_ex      <= w_id_data;
      r_ex_ctrl <= i_id_ctrl;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Counts only hazard/stall bubbles; flush bubbles are excluded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_bubble_cnt <= 32'd0;
    else if (w_bubble && !i_flush) r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign o_bubble_cnt = r_bubble_cnt;
`endif

  assign o_ex_valid      = r_ex.valid;
  assign o_ex_rf_we      = r_ex.rf_we;
  assign o_ex_mem_rd     = r_ex.mem_rd;
  assign o_ex_pc         = r_ex.pc;
  assign o_ex_rd1        = r_ex.rd1;
  assign o_ex_rd2        = r_ex.rd2;
  assign o_ex_imm        = r_ex.imm;
  assign o_ex_ra1        = r_ex.ra1;
  assign o_ex_ra2        = r_ex.ra2;
  assign o_ex_wa         = r_ex.wa;
  assign o_ex_ctrl       = r_ex_ctrl;
  assign o_stall_if_id_c = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench: two id_ex_stage instances (1 and 3 load-use stalls) vs a behavioural model.
// Bubble-counter checks are active when IDEX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;

  localparam int unsigned CW = 16;
  typedef logic [161:0] vec_t;

  logic          clk;
  logic          rst_n;
  logic          id_valid, id_use_ra1, id_use_ra2, id_rf_we, id_mem_rd, flush;
  logic [31:0]   id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]    id_ra1, id_ra2, id_wa;
  logic [CW-1:0] id_ctrl;

  logic          d_valid [2];
  logic          d_rf_we [2];
  logic          d_mem_rd[2];
  logic [31:0]   d_pc    [2];
  logic [31:0]   d_rd1   [2];
  logic [31:0]   d_rd2   [2];
  logic [31:0]   d_imm   [2];
  logic [4:0]    d_ra1   [2];
  logic [4:0]    d_ra2   [2];
  logic [4:0]    d_wa    [2];
  logic [CW-1:0] d_ctrl  [2];
  logic          d_stall [2];
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]   d_cnt   [2];
`endif

  // Model state: EX contents, stall cycles still owed, bubble count.
  vec_t          m_vec   [2];
  int            m_left  [2];
  logic [31:0]   m_cnt   [2];
  int            n_stalls[2];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CW), .LOAD_USE_STALLS(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rd1(id_rd1), .i_id_rd2(id_rd2), .i_id_imm(id_imm), .i_id_ra1(id_ra1),
    .i_id_ra2(id_ra2), .i_id_wa(id_wa), .i_id_use_ra1(id_use_ra1), .i_id_use_ra2(id_use_ra2),
    .i_id_rf_we(id_rf_we), .i_id_mem_rd(id_mem_rd), .i_id_ctrl(id_ctrl), .i_flush(flush),
    .o_ex_valid(d_valid[0]), .o_ex_rf_we(d_rf_we[0]), .o_ex_mem_rd(d_mem_rd[0]),
    .o_ex_pc(d_pc[0]), .o_ex_rd1(d_rd1[0]), .o_ex_rd2(d_rd2[0]), .o_ex_imm(d_imm[0]),
    .o_ex_ra1(d_ra1[0]), .o_ex_ra2(d_ra2[0]), .o_ex_wa(d_wa[0]), .o_ex_ctrl(d_ctrl[0]),
    .o_stall_if_id_c(d_stall[0])
`ifdef IDEX_BUBBLE_CNT_EN
    , .o_bubble_cnt(d_cnt[0])
`endif
  );

  id_ex_stage #(.CTRL_W(CW), .LOAD_USE_STALLS(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rd1(id_rd1), .i_id_rd2(id_rd2), .i_id_imm(id_imm), .i_id_ra1(id_ra1),
    .i_id_ra2(id_ra2), .i_id_wa(id_wa), .i_id_use_ra1(id_use_ra1), .i_id_use_ra2(id_use_ra2),
    .i_id_rf_we(id_rf_we), .i_id_mem_rd(id_mem_rd), .i_id_ctrl(id_ctrl), .i_flush(flush),
    .o_ex_valid(d_valid[1]), .o_ex_rf_we(d_rf_we[1]), .o_ex_mem_rd(d_mem_rd[1]),
    .o_ex_pc(d_pc[1]), .o_ex_rd1(d_rd1[1]), .o_ex_rd2(d_rd2[1]), .o_ex_imm(d_imm[1]),
    .o_ex_ra1(d_ra1[1]), .o_ex_ra2(d_ra2[1]), .o_ex_wa(d_wa[1]), .o_ex_ctrl(d_ctrl[1]),
    .o_stall_if_id_c(d_stall[1])
`ifdef IDEX_BUBBLE_CNT_EN
    , .o_bubble_cnt(d_cnt[1])
`endif
  );

  function automatic int stalls_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic vec_t dut_vec(input int k);
    return {d_valid[k], d_rf_we[k], d_mem_rd[k], d_pc[k], d_rd1[k], d_rd2[k], d_imm[k],
            d_ra1[k], d_ra2[k], d_wa[k], d_ctrl[k]};
  endfunction

  function automatic vec_t id_vec();
    return {id_valid, id_rf_we, id_mem_rd, id_pc, id_rd1, id_rd2, id_imm,
            id_ra1, id_ra2, id_wa, id_ctrl};
  endfunction

  // Load in EX (to a nonzero register) whose result the ID instruction reads.
  function automatic logic model_hazard(input int k);
    logic       v, ld;
    logic [4:0] wa;
    v  = m_vec[k][161];
    ld = m_vec[k][159];
    wa = m_vec[k][CW +: 5];
    return v && ld && (wa != 5'd0) && id_valid &&
           ((id_use_ra1 && id_ra1 == wa) || (id_use_ra2 && id_ra2 == wa));
  endfunction

  function automatic logic exp_stall(input int k);
    return !flush && (m_left[k] > 0 || model_hazard(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vec[k]  = '0;
      m_left[k] = 0;
      m_cnt[k]  = 32'd0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_vec[k]  = '0;
        m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_vec[k]  = '0;
        m_left[k] = m_left[k] - 1;
        m_cnt[k]  = m_cnt[k] + 32'd1;
      end else if (model_hazard(k)) begin
        m_vec[k]  = '0;
        m_left[k] = stalls_of(k) - 1;
        m_cnt[k]  = m_cnt[k] + 32'd1;
      end else begin
        m_vec[k]  = id_vec();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra1, input logic u1,
                        input logic [4:0] ra2, input logic u2, input logic [4:0] wa,
                        input logic we, input logic ld);
    id_valid = v; id_ra1 = ra1; id_use_ra1 = u1; id_ra2 = ra2; id_use_ra2 = u2;
    id_wa = wa; id_rf_we = we; id_mem_rd = ld;
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_ctrl = CW'($urandom);
  endtask

  task automatic idle(input int n);
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1);
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== '0) begin
        n_fail++; $display("FAIL reset_ex[%0d] got %h want 0", k, dut_vec(k));
      end
      n_tests++;
      if (d_stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_stall[%0d] got %b want 0", k, d_stall[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    id_pc = 32'h100;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL capture_stall[%0d] got %b want 0", k, d_stall[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_pc[k] !== 32'h100 || d_ra1[k] !== 5'd3 || d_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL capture_fields[%0d] got pc=%h ra1=%0d v=%b want pc=100 ra1=3 v=1",
                 k, d_pc[k], d_ra1[k], d_valid[k]);
      end
      n_tests++;
      if (dut_vec(k) !== m_vec[k]) begin
        n_fail++; $display("FAIL capture_ex[%0d] got %h want %h", k, dut_vec(k), m_vec[k]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] dep_pc;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] cnt0 [2];
`endif
    idle(4);
`ifdef IDEX_BUBBLE_CNT_EN
    for (int k = 0; k < 2; k++) cnt0[k] = d_cnt[k];
`endif
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    dep_pc = id_pc;
    n_stalls[0] = 0; n_stalls[1] = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        if (d_stall[k] === 1'b1) n_stalls[k]++;
        n_tests++;
        if (d_stall[k] !== exp_stall(k)) begin
          n_fail++;
          $display("FAIL load_use_stall[%0d] cyc %0d got %b want %b", k, c, d_stall[k], exp_stall(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== m_vec[k]) begin
          n_fail++; $display("FAIL load_use_ex[%0d] cyc %0d got %h want %h", k, c, dut_vec(k), m_vec[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (n_stalls[k] !== stalls_of(k)) begin
        n_fail++; $display("FAIL load_use_len[%0d] got %0d want %0d", k, n_stalls[k], stalls_of(k));
      end
      n_tests++;
      if (d_pc[k] !== dep_pc || d_valid[k] !== 1'b1) begin
        n_fail++; $display("FAIL load_use_dep[%0d] got pc=%h v=%b want pc=%h v=1", k, d_pc[k], d_valid[k], dep_pc);
      end
`ifdef IDEX_BUBBLE_CNT_EN
      n_tests++;
      if (d_cnt[k] !== cnt0[k] + 32'(stalls_of(k))) begin
        n_fail++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", k, d_cnt[k], cnt0[k] + 32'(stalls_of(k)));
      end
`endif
    end
  endtask

  task automatic test_no_stall();
    logic [4:0] ld_wa [2];
    logic [4:0] use_ra [2];
    logic       use_1  [2];
    ld_wa[0] = 5'd0; use_ra[0] = 5'd0; use_1[0] = 1'b1;
    ld_wa[1] = 5'd5; use_ra[1] = 5'd5; use_1[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      idle(4);
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, ld_wa[s], 1'b1, 1'b1);
      tick();
      if (use_1[s]) set_id(1'b1, use_ra[s], 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
      else          set_id(1'b1, 5'd7, 1'b1, use_ra[s], 1'b0, 5'd8, 1'b1, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (d_stall[k] !== 1'b0) begin
          n_fail++; $display("FAIL no_stall[%0d] case %0d got %b want 0", k, s, d_stall[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== m_vec[k]) begin
          n_fail++; $display("FAIL no_stall_ex[%0d] case %0d got %h want %h", k, s, dut_vec(k), m_vec[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] cnt0 [2];
`endif
    idle(4);
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
`ifdef IDEX_BUBBLE_CNT_EN
    for (int k = 0; k < 2; k++) cnt0[k] = d_cnt[k];
`endif
    set_id(1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL flush_stall[%0d] got %b want 0", k, d_stall[k]);
      end
    end
    tick();
    flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== '0) begin
        n_fail++; $display("FAIL flush_ex[%0d] got %h want 0", k, dut_vec(k));
      end
      n_tests++;
      if (d_stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL flush_run[%0d] got %b want 0", k, d_stall[k]);
      end
`ifdef IDEX_BUBBLE_CNT_EN
      n_tests++;
      if (d_cnt[k] !== cnt0[k]) begin
        n_fail++; $display("FAIL flush_cnt[%0d] got %0d want %0d", k, d_cnt[k], cnt0[k]);
      end
`endif
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== m_vec[k] || d_valid[k] !== 1'b1) begin
        n_fail++; $display("FAIL flush_after[%0d] got %h want %h", k, dut_vec(k), m_vec[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(4);
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== '0) begin
        n_fail++; $display("FAIL rst_mid_ex[%0d] got %h want 0", k, dut_vec(k));
      end
    end
    #2;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stall[%0d] got %b want 0", k, d_stall[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== m_vec[k] || d_valid[k] !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid_capture[%0d] got %h want %h", k, dut_vec(k), m_vec[k]);
      end
    end
  endtask

  // Load x5; load x6 from x5; add reading x6. ID advances once both stages are free.
  task automatic test_back_to_back();
    idle(4);
    for (int ins = 0; ins < 4; ins++) begin
      case (ins)
        0:       set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        1:       set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        2:       set_id(1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        default: set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      endcase
      for (int c = 0; c < 8; c++) begin
        #1;
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (d_stall[k] !== exp_stall(k)) begin
            n_fail++; $display("FAIL b2b_stall[%0d] ins %0d got %b want %b", k, ins, d_stall[k], exp_stall(k));
          end
        end
        if (!exp_stall(0) && !exp_stall(1) && c > 0) break;
        tick();
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (dut_vec(k) !== m_vec[k]) begin
            n_fail++; $display("FAIL b2b_ex[%0d] ins %0d got %h want %h", k, ins, dut_vec(k), m_vec[k]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (d_stall[k] !== exp_stall(k)) begin
          n_fail++; $display("FAIL rand_stall[%0d] cyc %0d got %b want %b", k, c, d_stall[k], exp_stall(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== m_vec[k]) begin
          n_fail++; $display("FAIL rand_ex[%0d] cyc %0d got %h want %h", k, c, dut_vec(k), m_vec[k]);
        end
`ifdef IDEX_BUBBLE_CNT_EN
        n_tests++;
        if (d_cnt[k] !== m_cnt[k]) begin
          n_fail++; $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", k, c, d_cnt[k], m_cnt[k]);
        end
`endif
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_no_stall();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
